// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioning chain.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_HOLD_CYCLES     = 16;
    localparam int DEF_REPEAT_CYCLES   = 4;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic synced
);

    logic s1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1     <= 1'b0;
            synced <= 1'b0;
        end else begin
            s1     <= async_in;
            synced <= s1;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Raw button -> synchronized, debounced level plus press/release/long-press/repeat pulses.
//
// state     | meaning
// ST_IDLE   | button released (or not yet debounced high)
// ST_HELD   | pressed, timing toward long_press
// ST_REPEAT | held past long_press, emitting periodic repeat pulses
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic noisy_in,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int HW = cnt_width((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
    localparam logic [DW-1:0] D_TC   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_TC   = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] R_TC   = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam logic          RPT_EN = (REPEAT_CYCLES != 0);

    logic          synced;
    logic [DW-1:0] cnt;
    logic          flip;
    logic          rise;
    logic          fall;

    sync_2ff u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (noisy_in),
        .synced   (synced)
    );

    // rise/fall are the debounce flip conditions seen before the edge, so the
    // FSM reacts on the same edge that updates level.
    assign flip = (synced != level) && (cnt == D_TC);
    assign rise = flip && synced;
    assign fall = flip && !synced;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level         <= 1'b0;
            cnt           <= '0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= rise;
            release_pulse <= fall;
            if (synced == level) begin
                cnt <= '0;
            end else if (cnt == D_TC) begin
                level <= synced;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    btn_state_t    state;
    btn_state_t    state_next;
    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcnt_next;
    logic          long_next;
    logic          rpt_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            hcnt         <= '0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            state        <= state_next;
            hcnt         <= hcnt_next;
            long_press   <= long_next;
            repeat_pulse <= rpt_next;
        end
    end

    always_comb begin
        state_next = state;
        hcnt_next  = hcnt;
        if (fall) begin
            state_next = ST_IDLE;
            hcnt_next  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state_next = ST_HELD;
                        hcnt_next  = '0;
                    end
                end
                ST_HELD: begin
                    if (hcnt == H_TC) begin
                        state_next = ST_REPEAT;
                        hcnt_next  = '0;
                    end else begin
                        hcnt_next = hcnt + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (RPT_EN) begin
                        if (hcnt == R_TC) hcnt_next = '0;
                        else              hcnt_next = hcnt + 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    hcnt_next  = '0;
                end
            endcase
        end
    end

    // A release on this edge suppresses any long/repeat pulse.
    always_comb begin
        long_next = 1'b0;
        rpt_next  = 1'b0;
        if (!fall) begin
            case (state)
                ST_HELD:   long_next = (hcnt == H_TC);
                ST_REPEAT: rpt_next  = RPT_EN && (hcnt == R_TC);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: vector table, corner sequences, random vs. model.
module tb_btn_conditioner;
    import btn_pkg::*;

    localparam int D = 4;
    localparam int H = 16;
    localparam int R = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic noisy_in = 1'b0;
    logic level, press, release_pulse, long_press, repeat_pulse;

    int checks = 0;
    int errors = 0;

    btn_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .noisy_in      (noisy_in),
        .level         (level),
        .press         (press),
        .release_pulse (release_pulse),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: sync pipeline, run length of disagreement, press timestamp.
    bit m_s1, m_s2, m_level, m_held;
    int m_run, m_edge, m_press_at;
    bit e_level, e_press, e_rel, e_long, e_rpt;

    // Per-sequence pulse statistics (tick numbers are 1-based since the last reset release).
    int tcount;
    int n_press, n_rel, n_long, n_rpt;
    int t_press, t_rel, t_long, t_rpt1;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_level = 0; m_held = 0;
        m_run = 0; m_edge = 0; m_press_at = 0;
        e_level = 0; e_press = 0; e_rel = 0; e_long = 0; e_rpt = 0;
    endtask

    task automatic model_step(input bit v);
        bit s2_old;
        int age;
        s2_old = m_s2;
        m_s2 = m_s1;
        m_s1 = v;
        m_edge++;
        e_press = 0; e_rel = 0; e_long = 0; e_rpt = 0;
        if (s2_old != m_level) begin
            m_run++;
            if (m_run == D) begin
                m_level = s2_old;
                m_run = 0;
                if (m_level) begin
                    e_press = 1; m_held = 1; m_press_at = m_edge;
                end else begin
                    e_rel = 1; m_held = 0;
                end
            end
        end else begin
            m_run = 0;
        end
        if (m_held && !e_press) begin
            age = m_edge - m_press_at;
            if (age == H) e_long = 1;
            else if (R != 0 && age > H && (age - H) % R == 0) e_rpt = 1;
        end
        e_level = m_level;
    endtask

    task automatic clear_stats();
        tcount = 0;
        n_press = 0; n_rel = 0; n_long = 0; n_rpt = 0;
        t_press = -1; t_rel = -1; t_long = -1; t_rpt1 = -1;
    endtask

    task automatic tick(input bit v, input bit cmp);
        @(negedge clk);
        noisy_in = v;
        @(posedge clk);
        model_step(v);
        #1;
        tcount++;
        if (press)         begin n_press++; if (t_press < 0) t_press = tcount; end
        if (release_pulse) begin n_rel++;   if (t_rel   < 0) t_rel   = tcount; end
        if (long_press)    begin n_long++;  if (t_long  < 0) t_long  = tcount; end
        if (repeat_pulse)  begin n_rpt++;   if (t_rpt1  < 0) t_rpt1  = tcount; end
        if (cmp) begin
            check("mdl_level",   level,         e_level);
            check("mdl_press",   press,         e_press);
            check("mdl_release", release_pulse, e_rel);
            check("mdl_long",    long_press,    e_long);
            check("mdl_repeat",  repeat_pulse,  e_rpt);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        noisy_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        clear_stats();
    endtask

    typedef struct {
        logic       in;
        logic [4:0] exp;   // {level, press, release, long, repeat}
    } vec_t;

    vec_t vecs[18];

    initial begin
        for (int i = 0; i < 18; i++) begin
            vecs[i].in = (i < 10);
            if (i < 5)        vecs[i].exp = 5'b00000;
            else if (i == 5)  vecs[i].exp = 5'b11000;
            else if (i < 15)  vecs[i].exp = 5'b10000;
            else if (i == 15) vecs[i].exp = 5'b00100;
            else              vecs[i].exp = 5'b00000;
        end

        // Reset state
        rst = 1'b0;
        #12;
        check("rst_level",   level,         1'b0);
        check("rst_press",   press,         1'b0);
        check("rst_release", release_pulse, 1'b0);
        check("rst_long",    long_press,    1'b0);
        check("rst_repeat",  repeat_pulse,  1'b0);
        do_reset();

        // Clean press then release, from the vector table
        for (int i = 0; i < 18; i++) begin
            tick(vecs[i].in, 1'b0);
            check("vec_level",   level,         vecs[i].exp[4]);
            check("vec_press",   press,         vecs[i].exp[3]);
            check("vec_release", release_pulse, vecs[i].exp[2]);
            check("vec_long",    long_press,    vecs[i].exp[1]);
            check("vec_repeat",  repeat_pulse,  vecs[i].exp[0]);
        end

        // Glitch shorter than the debounce window
        do_reset();
        for (int i = 0; i < 15; i++) tick(i < 3, 1'b1);
        check_int("glitch_press", n_press, 0);
        check_int("glitch_rel",   n_rel,   0);
        check_int("glitch_long",  n_long,  0);
        check("glitch_level", level, 1'b0);

        // Bounce: only the final stable run counts
        do_reset();
        begin
            bit pat [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
            for (int i = 0; i < 9; i++) tick(pat[i], 1'b1);
            for (int i = 0; i < 11; i++) tick(1'b1, 1'b1);
        end
        check_int("bounce_press_cnt", n_press, 1);
        check_int("bounce_press_t",   t_press, 11);

        // Long hold with auto-repeat, then release
        do_reset();
        for (int i = 0; i < 55; i++) tick(i < 45, 1'b1);
        check_int("hold_press_t", t_press, 6);
        check_int("hold_long_t",  t_long,  6 + H);
        check_int("hold_long_n",  n_long,  1);
        check_int("hold_rpt1_t",  t_rpt1,  6 + H + R);
        check_int("hold_rpt_n",   n_rpt,   7);
        check_int("hold_rel_t",   t_rel,   51);
        check_int("hold_rel_n",   n_rel,   1);

        // Release lands on the edge that would have fired long_press
        do_reset();
        for (int i = 0; i < 26; i++) tick(i < 16, 1'b1);
        check_int("edge_rel_t",  t_rel,  6 + H);
        check_int("edge_long_n", n_long, 0);
        check_int("edge_rpt_n",  n_rpt,  0);
        check_int("edge_state",  int'(dut.state), int'(ST_IDLE));

        // Asynchronous reset mid-REPEAT while still held
        do_reset();
        for (int i = 0; i < 34; i++) tick(1'b1, 1'b1);
        check("pre_rst_repeat", repeat_pulse, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("async_level",  level,        1'b0);
        check("async_repeat", repeat_pulse, 1'b0);
        check("async_press",  press,        1'b0);
        check("async_long",   long_press,   1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        clear_stats();
        for (int i = 0; i < 30; i++) tick(1'b1, 1'b1);
        check_int("rerst_press_t", t_press, 6);
        check_int("rerst_long_t",  t_long,  6 + H);
        check_int("rerst_rpt1_t",  t_rpt1,  6 + H + R);

        // Random runs of varying length against the model
        do_reset();
        for (int seg = 0; seg < 200; seg++) begin
            bit v;
            int len;
            v = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 40));
            for (int k = 0; k < len; k++) begin
                tick(v, 1'b1);
                check_int("one_hot_pulses",
                          int'(press) + int'(release_pulse) + int'(long_press) + int'(repeat_pulse) > 1 ? 1 : 0, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
